// File: rtl/axi_slave_mem_model_if.sv
// ---------------------------------------------------------------------------
// axi_slave_mem_model_if
// AXI4 bus bundle (AW, W, B, AR, R channels) for axi_slave_mem_model.
// Parameters: ADDR_W (address width), DATA_W (data width, 32/64/128).
// Modports:
//   slave  - memory-model side: takes the descriptors, W data and the
//            B/R ready signals; drives the readies, B response and R data.
//   master - initiator side, the mirror image of slave.
// Handshake rule for every channel: a beat transfers on a rising clk edge
// where valid and ready are both high. Once valid is high the sender holds
// the payload stable until that transfer.
// ---------------------------------------------------------------------------
interface axi_slave_mem_model_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic [7:0]          s_axi_awlen;
  logic [2:0]          s_axi_awsize;
  logic [1:0]          s_axi_awburst;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wlast;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic [7:0]          s_axi_arlen;
  logic [2:0]          s_axi_arsize;
  logic [1:0]          s_axi_arburst;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rlast;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );
endinterface

// File: rtl/axi_slave_mem_model.sv
// ---------------------------------------------------------------------------
// axi_slave_mem_model
// AXI4 slave backed by real storage. It handles one transaction at a time,
// supports FIXED/INCR bursts and byte strobes, and returns SLVERR for bad
// accesses. When both AW and AR request at once, it alternates between them.
// Parameters: DATA_W (32/64/128), ADDR_W, MEM_DEPTH (words), BASE_ADDR
//             (byte address of word 0), RD_LAT (idle cycles, 0..15).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   s_axi       - AXI4 bus (slave modport of axi_slave_mem_model_if)
//   busy_o      - high whenever the FSM is not IDLE
//   proto_err_o - one-cycle pulse when wlast disagrees with the beat count
//   state_o     - current FSM state (debug)
// Optional macro AXI_MEM_MODEL_BACKPRESSURE_EN: an LFSR-driven stall
// randomly drops wready and delays raising rvalid.
// ---------------------------------------------------------------------------
module axi_slave_mem_model #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_slave_mem_model_if.slave s_axi,
  output logic                 busy_o,
  output logic                 proto_err_o,
  output logic [2:0]           state_o
);
  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(MEM_DEPTH);
  localparam logic [2:0]        SIZE_OK  = 3'(SHIFT);
  localparam logic              LAT_ZERO = (RD_LAT == 0);
  localparam logic [3:0]        LAT_INIT = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_RESP = 3'd2,
    RD_WAIT = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t            state_q;
  logic              last_rd_q;   // 1: read was served last, so write wins a tie
  logic [ADDR_W-1:0] idx_q;
  logic              below_q;     // start address was below BASE_ADDR
  logic              err_q;       // bad size or burst type
  logic              incr_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_q;
  logic [3:0]        lat_q;
  logic              slverr_q;
  logic              proto_err_q;
  logic              rv_hold_q;   // rvalid already shown and not yet taken
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // Descriptor selected by the grant, used only on the handshake cycle.
  logic              wr_gnt, rd_gnt, in_idle;
  logic [ADDR_W-1:0] hs_addr_d;
  logic [ADDR_W:0]   hs_diff_d;
  logic [7:0]        hs_len_d;
  logic [2:0]        hs_size_d;
  logic [1:0]        hs_burst_d;
  logic [ADDR_W-1:0] idx_d;
  logic              oob, beat_err, is_last, stall, w_fire, r_fire;

`ifdef AXI_MEM_MODEL_BACKPRESSURE_EN
  logic [7:0] lfsr_q;
  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign wr_gnt  = s_axi.s_axi_awvalid && (!s_axi.s_axi_arvalid || last_rd_q);
  assign rd_gnt  = s_axi.s_axi_arvalid && !wr_gnt;
  assign in_idle = (state_q == IDLE) && !reset;
  assign s_axi.s_axi_awready = in_idle && wr_gnt;
  assign s_axi.s_axi_arready = in_idle && rd_gnt;

  assign hs_addr_d  = wr_gnt ? s_axi.s_axi_awaddr  : s_axi.s_axi_araddr;
  assign hs_len_d   = wr_gnt ? s_axi.s_axi_awlen   : s_axi.s_axi_arlen;
  assign hs_size_d  = wr_gnt ? s_axi.s_axi_awsize  : s_axi.s_axi_arsize;
  assign hs_burst_d = wr_gnt ? s_axi.s_axi_awburst : s_axi.s_axi_arburst;
  // Borrow out of the subtraction flags an address below BASE_ADDR.
  assign hs_diff_d  = {1'b0, hs_addr_d} - {1'b0, BASE_ADDR};

  assign oob      = below_q || (idx_q >= DEPTH_A);
  assign beat_err = err_q || oob;
  assign is_last  = (beat_q == len_q);
  assign idx_d    = incr_q ? idx_q + 1'b1 : idx_q;

  assign s_axi.s_axi_wready = (state_q == WR_DATA) && !stall;
  assign w_fire = s_axi.s_axi_wvalid && s_axi.s_axi_wready;

  assign s_axi.s_axi_bvalid = (state_q == WR_RESP);
  assign s_axi.s_axi_bresp  = (s_axi.s_axi_bvalid && slverr_q) ? 2'b10 : 2'b00;

  // R payload is decoded from registers that only move on a handshake, so
  // it stays stable while the master stalls.
  assign s_axi.s_axi_rvalid = (state_q == RD_DATA) && (rv_hold_q || !stall);
  assign s_axi.s_axi_rdata  = (s_axi.s_axi_rvalid && !beat_err) ? mem_q[idx_q[IDX_W-1:0]] : '0;
  assign s_axi.s_axi_rresp  = (s_axi.s_axi_rvalid && beat_err) ? 2'b10 : 2'b00;
  assign s_axi.s_axi_rlast  = s_axi.s_axi_rvalid && is_last;
  assign r_fire = s_axi.s_axi_rvalid && s_axi.s_axi_rready;

  assign busy_o      = (state_q != IDLE);
  assign proto_err_o = proto_err_q;
  assign state_o     = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_rd_q   <= 1'b1;
      idx_q       <= '0;
      below_q     <= 1'b0;
      err_q       <= 1'b0;
      incr_q      <= 1'b0;
      len_q       <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
      slverr_q    <= 1'b0;
      proto_err_q <= 1'b0;
      rv_hold_q   <= 1'b0;
    end else begin
      proto_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_axi.s_axi_awready || s_axi.s_axi_arready) begin
            idx_q     <= hs_diff_d[ADDR_W-1:0] >> SHIFT;
            below_q   <= hs_diff_d[ADDR_W];
            len_q     <= hs_len_d;
            incr_q    <= (hs_burst_d == 2'b01);
            err_q     <= (hs_size_d != SIZE_OK) || hs_burst_d[1];
            beat_q    <= '0;
            slverr_q  <= 1'b0;
            rv_hold_q <= 1'b0;
            if (s_axi.s_axi_awready) begin
              state_q <= WR_DATA;
            end else if (LAT_ZERO) begin
              state_q <= RD_DATA;
            end else begin
              state_q <= RD_WAIT;
              lat_q   <= LAT_INIT;
            end
          end
        end
        WR_DATA: begin
          if (w_fire) begin
            if (beat_err) slverr_q <= 1'b1;
            proto_err_q <= (s_axi.s_axi_wlast != is_last);
            idx_q       <= idx_d;
            beat_q      <= beat_q + 8'd1;
            // The beat count, not wlast, ends the burst.
            if (is_last) state_q <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (s_axi.s_axi_bready) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (lat_q == 4'd0) state_q <= RD_DATA;
          else               lat_q   <= lat_q - 4'd1;
        end
        RD_DATA: begin
          if (r_fire) begin
            rv_hold_q <= 1'b0;
            if (is_last) begin
              state_q   <= IDLE;
              last_rd_q <= 1'b1;
            end else begin
              beat_q <= beat_q + 8'd1;
              idx_q  <= idx_d;
            end
          end else if (s_axi.s_axi_rvalid) begin
            rv_hold_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage has no reset; contents survive a reset of the control logic.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == WR_DATA) && w_fire && !beat_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi.s_axi_wstrb[b]) mem_q[idx_q[IDX_W-1:0]][8*b +: 8] <= s_axi.s_axi_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_slave_mem_model.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_mem_model
// Directed bench for axi_slave_mem_model (DATA_W=32, MEM_DEPTH=256,
// BASE_ADDR=0, RD_LAT=1). Inputs change on the falling edge and outputs are
// sampled 1ns after it, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_axi_slave_mem_model;
  logic       clk = 1'b0;
  logic       reset;
  logic       busy_o, proto_err_o;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  int proto_cnt = 0;
  int rd_wait;

  logic [31:0] wd  [16];
  logic [3:0]  ws  [16];
  logic [31:0] rdv [16];
  logic [1:0]  rrv [16];
  logic        rlv [16];
  logic [1:0]  bresp;

  axi_slave_mem_model_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi_slave_mem_model #(
    .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256), .BASE_ADDR(32'h0), .RD_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .s_axi(axi),
    .busy_o(busy_o), .proto_err_o(proto_err_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (proto_err_o) proto_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: entered and left on a falling edge
  task automatic aw_hs(input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    axi.s_axi_awaddr = addr; axi.s_axi_awlen = len;
    axi.s_axi_awsize = size; axi.s_axi_awburst = burst; axi.s_axi_awvalid = 1'b1;
    #1;
    while (!axi.s_axi_awready && n < 64) begin @(negedge clk); #1; n++; end
    check("aw_handshake", axi.s_axi_awready, 1);
    @(posedge clk); @(negedge clk);
    axi.s_axi_awvalid = 1'b0;
  endtask

  task automatic ar_hs(input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    axi.s_axi_araddr = addr; axi.s_axi_arlen = len;
    axi.s_axi_arsize = size; axi.s_axi_arburst = burst; axi.s_axi_arvalid = 1'b1;
    #1;
    while (!axi.s_axi_arready && n < 64) begin @(negedge clk); #1; n++; end
    check("ar_handshake", axi.s_axi_arready, 1);
    @(posedge clk); @(negedge clk);
    axi.s_axi_arvalid = 1'b0;
  endtask

  // wlast is driven from beat wlast_from onward; wlast_from == len is legal.
  task automatic w_beats(input int len, input int wlast_from);
    for (int b = 0; b <= len; b++) begin
      int n = 0;
      axi.s_axi_wdata = wd[b]; axi.s_axi_wstrb = ws[b];
      axi.s_axi_wlast = (b >= wlast_from); axi.s_axi_wvalid = 1'b1;
      #1;
      while (!axi.s_axi_wready && n < 64) begin @(negedge clk); #1; n++; end
      check("w_handshake", axi.s_axi_wready, 1);
      @(posedge clk); @(negedge clk);
      if (b < len) check("no_early_bvalid", axi.s_axi_bvalid, 0);
    end
    axi.s_axi_wvalid = 1'b0; axi.s_axi_wlast = 1'b0;
  endtask

  task automatic b_wait(output logic [1:0] resp);
    int n = 0;
    axi.s_axi_bready = 1'b1;
    #1;
    while (!axi.s_axi_bvalid && n < 64) begin @(negedge clk); #1; n++; end
    check("bvalid_seen", axi.s_axi_bvalid, 1);
    resp = axi.s_axi_bresp;
    @(posedge clk); @(negedge clk);
    axi.s_axi_bready = 1'b0;
  endtask

  task automatic r_collect(input int len, input bit hold_first);
    axi.s_axi_rready = !hold_first;
    for (int b = 0; b <= len; b++) begin
      int n = 0;
      #1;
      while (!axi.s_axi_rvalid && n < 64) begin @(negedge clk); #1; n++; end
      if (b == 0) rd_wait = n;
      check("rvalid_seen", axi.s_axi_rvalid, 1);
      rdv[b] = axi.s_axi_rdata; rrv[b] = axi.s_axi_rresp; rlv[b] = axi.s_axi_rlast;
      if (b == 0 && hold_first) begin
        @(posedge clk); @(negedge clk); #1;
        check("r_hold_valid", axi.s_axi_rvalid, 1);
        check("r_hold_data", axi.s_axi_rdata, rdv[0]);
        axi.s_axi_rready = 1'b1;
      end
      @(posedge clk); @(negedge clk);
    end
    axi.s_axi_rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, output logic [1:0] resp);
    aw_hs(addr, 8'(len), size, burst);
    w_beats(len, len);
    b_wait(resp);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input bit hold_first);
    ar_hs(addr, 8'(len), 3'd2, 2'b01);
    r_collect(len, hold_first);
  endtask

  // scoreboard: expected read data queued per test, popped per beat
  logic [31:0] exp_q[$];

  task automatic score_reads(input string tag, input int len);
    for (int b = 0; b <= len; b++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check({tag, "_data"}, rdv[b], e);
      check({tag, "_rlast"}, rlv[b], (b == len));
    end
  endtask

  initial begin
    reset = 1'b1;
    axi.s_axi_awaddr = '0; axi.s_axi_awlen = '0; axi.s_axi_awsize = '0; axi.s_axi_awburst = '0;
    axi.s_axi_awvalid = 1'b0; axi.s_axi_wdata = '0; axi.s_axi_wstrb = '0; axi.s_axi_wlast = 1'b0;
    axi.s_axi_wvalid = 1'b0; axi.s_axi_bready = 1'b0; axi.s_axi_araddr = '0; axi.s_axi_arlen = '0;
    axi.s_axi_arsize = '0; axi.s_axi_arburst = '0; axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_state", state_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_wready", axi.s_axi_wready, 0);
    check("rst_bvalid", axi.s_axi_bvalid, 0);
    check("rst_rvalid", axi.s_axi_rvalid, 0);
    check("rst_proto", proto_err_o, 0);
    @(negedge clk);

    // INCR write of 4 words at 0x10, read back with a held first beat
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h11111111 * (i + 1); ws[i] = 4'hF; end
    do_write(32'h10, 3, 2'b01, 3'd2, bresp);
    check("incr_bresp", bresp, 2'b00);
    do_read(32'h10, 3, 1'b1);
    check("incr_rd_latency", rd_wait, 1);
    exp_q.push_back(32'h11111111); exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h33333333); exp_q.push_back(32'h44444444);
    score_reads("incr", 3);
    for (int i = 0; i < 4; i++) check("incr_rresp", rrv[i], 2'b00);

    // byte strobes
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h20, 0, 2'b01, 3'd2, bresp);
    wd[0] = 32'h00CC00AA; ws[0] = 4'b0101;
    do_write(32'h20, 0, 2'b01, 3'd2, bresp);
    do_read(32'h20, 0, 1'b0);
    exp_q.push_back(32'hDECCBEAA);
    score_reads("strb", 0);

    // INCR off the end of storage
    wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h3FC, 1, 2'b01, 3'd2, bresp);
    check("oob_bresp", bresp, 2'b10);
    do_read(32'h3FC, 1, 1'b0);
    exp_q.push_back(32'hCAFE0001); exp_q.push_back(32'h0);
    score_reads("oob", 1);
    check("oob_rresp0", rrv[0], 2'b00);
    check("oob_rresp1", rrv[1], 2'b10);

    // FIXED burst keeps the same word: last beat wins
    wd[0] = 32'hAAAA0001; wd[1] = 32'hBBBB0002;
    do_write(32'h80, 1, 2'b00, 3'd2, bresp);
    check("fixed_bresp", bresp, 2'b00);
    do_read(32'h80, 0, 1'b0);
    exp_q.push_back(32'hBBBB0002);
    score_reads("fixed", 0);

    // bad size: SLVERR and the word is untouched
    wd[0] = 32'h5A5A5A5A;
    do_write(32'h90, 0, 2'b01, 3'd2, bresp);
    wd[0] = 32'h12345678;
    do_write(32'h90, 0, 2'b01, 3'd3, bresp);
    check("badsize_bresp", bresp, 2'b10);
    do_read(32'h90, 0, 1'b0);
    exp_q.push_back(32'h5A5A5A5A);
    score_reads("badsize", 0);

    // simultaneous AW/AR: write, then read, then write again
    axi.s_axi_awaddr = 32'hA0; axi.s_axi_awlen = 8'd0; axi.s_axi_awsize = 3'd2;
    axi.s_axi_awburst = 2'b01; axi.s_axi_awvalid = 1'b1;
    axi.s_axi_araddr = 32'h10; axi.s_axi_arlen = 8'd0; axi.s_axi_arsize = 3'd2;
    axi.s_axi_arburst = 2'b01; axi.s_axi_arvalid = 1'b1;
    #1;
    check("arb1_awready", axi.s_axi_awready, 1);
    check("arb1_arready", axi.s_axi_arready, 0);
    aw_hs(32'hA0, 8'd0, 3'd2, 2'b01);
    check("arb1_busy", busy_o, 1);
    wd[0] = 32'h0BADF00D; ws[0] = 4'hF;
    w_beats(0, 0);
    b_wait(bresp);
    axi.s_axi_awvalid = 1'b1;
    #1;
    check("arb2_arready", axi.s_axi_arready, 1);
    check("arb2_awready", axi.s_axi_awready, 0);
    ar_hs(32'hA0, 8'd0, 3'd2, 2'b01);
    check("arb2_busy", busy_o, 1);
    r_collect(0, 1'b0);
    exp_q.push_back(32'h0BADF00D);
    score_reads("arb_rd", 0);
    axi.s_axi_arvalid = 1'b1;
    #1;
    check("arb3_awready", axi.s_axi_awready, 1);
    check("arb3_arready", axi.s_axi_arready, 0);
    aw_hs(32'hA4, 8'd0, 3'd2, 2'b01);
    wd[0] = 32'h600DF00D;
    w_beats(0, 0);
    b_wait(bresp);
    ar_hs(32'hA4, 8'd0, 3'd2, 2'b01);
    r_collect(0, 1'b0);
    exp_q.push_back(32'h600DF00D);
    score_reads("arb_rd2", 0);

    // early wlast: one protocol-error pulse, beat count still completes
    proto_cnt = 0;
    for (int i = 0; i < 3; i++) begin wd[i] = 32'h60000000 + i; ws[i] = 4'hF; end
    aw_hs(32'h60, 8'd2, 3'd2, 2'b01);
    w_beats(2, 1);
    check("proto_state_wr_resp", state_o, 2);
    b_wait(bresp);
    check("proto_bresp", bresp, 2'b00);
    check("proto_pulses", proto_cnt, 1);

    // reset during the second beat of a 4-beat read
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h40400000 + i; ws[i] = 4'hF; end
    do_write(32'h40, 3, 2'b01, 3'd2, bresp);
    ar_hs(32'h40, 8'd3, 3'd2, 2'b01);
    begin
      int n = 0;
      axi.s_axi_rready = 1'b1;
      #1;
      while (!axi.s_axi_rvalid && n < 64) begin @(negedge clk); #1; n++; end
      @(posedge clk); @(negedge clk); #1;
      check("rst_mid_beat2_valid", axi.s_axi_rvalid, 1);
      check("rst_mid_beat2_data", axi.s_axi_rdata, 32'h40400001);
      reset = 1'b1; axi.s_axi_rready = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      check("rst_mid_rvalid", axi.s_axi_rvalid, 0);
      check("rst_mid_state", state_o, 0);
      check("rst_mid_busy", busy_o, 0);
      reset = 1'b0;
      @(negedge clk);
    end
    do_read(32'h40, 3, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h40400000 + i);
    score_reads("after_rst", 3);
    do_read(32'h10, 0, 1'b0);
    exp_q.push_back(32'h11111111);
    score_reads("retained", 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
